corrector: RTL and testbench

Reed-Solomon (t=2) error corrector downstream of the syndrome block on the decode path. It buffers one segment of received bytes, takes the four syndromes s0..s3 when the syndrome block pulses synReady, and solves for up to two error locations and values in GF(256) (x^8+x^4+x^3+x^2+1). It then runs a Chien search pass and an output pass, streaming the corrected segment with error status.

---
 rtl/corrector.sv | 252 +++++++++++++++++++++++++
 tb/tb_corrector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/corrector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// corrector : RS (t=2) GF(256) corrector - buffer, solve, Chien search, emit.
// Option macro RSDEC_STRIP_PARITY_EN: parity bytes corrected but not emitted.
// Revision 1.0
// ---------------------------------------------------------------------------
module corrector #(
  parameter int SEG_LEN = 176
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       abort,
  input  logic [7:0] dataI,
  input  logic       dataValid,
  input  logic [7:0] s0,
  input  logic [7:0] s1,
  input  logic [7:0] s2,
  input  logic [7:0] s3,
  input  logic       synReady,
  output logic       busy,
  output logic [7:0] dataO,
  output logic       dataOValid,
  output logic       segDone,
  output logic [1:0] errCount,
  output logic       uncorrectable
);

`ifdef RSDEC_STRIP_PARITY_EN
  localparam int N_OUT = SEG_LEN - 4;
`else
  localparam int N_OUT = SEG_LEN;
`endif
  localparam logic [7:0] c_SEG   = 8'(SEG_LEN);
  localparam logic [7:0] c_LAST  = 8'(SEG_LEN - 1);
  localparam logic [7:0] c_NOUT  = 8'(N_OUT);
  localparam logic [7:0] c_OLAST = 8'(N_OUT - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_SOLVE, ST_SEARCH, ST_EMIT} state_t;
  typedef enum logic [1:0] {M_NONE, M_ONE, M_TWO, M_FAIL} mode_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  // a^254 = product of a^2, a^4, ..., a^128; maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] loc_step(input logic [7:0] a);
    return {a[0], a[7:5], a[4] ^ a[0], a[3] ^ a[0], a[2] ^ a[0], a[1]};
  endfunction

  function automatic logic is_root(input mode_t m, input logic [7:0] x, input logic [7:0] xs,
                                   input logic [7:0] g1, input logic [7:0] g2);
    logic r;
    r = 1'b0;
    if (m == M_ONE) r = (x == xs);
    else if (m == M_TWO) r = ((gf_mul(x, x) ^ gf_mul(g1, x) ^ g2) == 8'h00);
    return r;
  endfunction

  state_t     state_q, state_d;
  mode_t      mode_q, mode_d;
  logic [7:0] k_q, k_d;
  logic       lenerr_q, lenerr_d;
  logic [7:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [7:0] invs0_q, invs0_d, dt_q, dt_d, invdt_q, invdt_d, xs_q, xs_d;
  logic [7:0] sig1n_q, sig1n_d, sig1_q, sig1_d, sig2_q, sig2_d, invsig1_q, invsig1_d;
  logic [1:0] roots_q, roots_d;
  logic [7:0] loc_q, loc_d;
  logic [7:0] dout_q, dout_d;
  logic       dov_q, dov_d, done_q, done_d, unc_q, unc_d;
  logic [1:0] errc_q, errc_d;

  logic [7:0] mem [SEG_LEN];
  logic       w_we;
  logic [7:0] w_waddr;

  logic [7:0] w_sig1, w_inv_in, w_inv;
  logic       w_sroot, w_eroot, w_emitting;
  logic [1:0] w_roots_nx;
  mode_t      w_mode_fin, w_emode;
  logic [7:0] w_eidx, w_eloc, w_eval, w_dout;

  assign w_sig1 = gf_mul(sig1n_q, invdt_q);

  // Single inverter shared by the three solve cycles
  always_comb begin
    case (k_q[1:0])
      2'd0:    w_inv_in = s0_q;
      2'd1:    w_inv_in = dt_q;
      default: w_inv_in = w_sig1;
    endcase
  end
  assign w_inv = gf_inv(w_inv_in);

  assign w_sroot    = is_root(mode_q, loc_q, xs_q, sig1_q, sig2_q);
  assign w_roots_nx = (roots_q == 2'd3) ? 2'd3 : roots_q + {1'b0, w_sroot};

  always_comb begin
    w_mode_fin = mode_q;
    if ((mode_q == M_ONE && w_roots_nx != 2'd1) || (mode_q == M_TWO && w_roots_nx != 2'd2))
      w_mode_fin = M_FAIL;
  end

  // Output registers are loaded one cycle ahead: byte 0 during the last search cycle
  assign w_emitting = (state_q == ST_SEARCH && k_q == c_LAST) || (state_q == ST_EMIT && k_q < c_NOUT);
  assign w_eidx     = (state_q == ST_EMIT && k_q < c_NOUT) ? k_q : 8'd0;
  assign w_eloc     = (state_q == ST_EMIT) ? loc_q : 8'hFF;
  assign w_emode    = (state_q == ST_EMIT) ? mode_q : w_mode_fin;
  assign w_eroot    = is_root(w_emode, w_eloc, xs_q, sig1_q, sig2_q);

  always_comb begin
    w_eval = 8'h00;
    if (w_eroot && w_emode == M_ONE) w_eval = s0_q;
    else if (w_eroot && w_emode == M_TWO)
      w_eval = gf_mul(s1_q ^ gf_mul(s0_q, w_eloc ^ sig1_q), invsig1_q);
  end
  assign w_dout = mem[w_eidx] ^ w_eval;

  always_comb begin
    state_d = state_q;   mode_d = mode_q;     k_d = k_q;           lenerr_d = lenerr_q;
    s0_d = s0_q;         s1_d = s1_q;         s2_d = s2_q;         s3_d = s3_q;
    invs0_d = invs0_q;   dt_d = dt_q;         invdt_d = invdt_q;   xs_d = xs_q;
    sig1n_d = sig1n_q;   sig1_d = sig1_q;     sig2_d = sig2_q;     invsig1_d = invsig1_q;
    roots_d = roots_q;   loc_d = loc_q;       dout_d = dout_q;
    dov_d = 1'b0;        done_d = 1'b0;       errc_d = 2'd0;       unc_d = 1'b0;
    w_we = 1'b0;         w_waddr = k_q;
    case (state_q)
      ST_IDLE: begin
        if (dataValid) begin
          w_we = 1'b1;  w_waddr = 8'd0;  k_d = 8'd1;  lenerr_d = 1'b0;  state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (dataValid) begin
          if (k_q < c_SEG) begin
            w_we = 1'b1;  k_d = k_q + 8'd1;
          end else begin
            lenerr_d = 1'b1;
          end
        end
        if (synReady) begin
          s0_d = s0;  s1_d = s1;  s2_d = s2;  s3_d = s3;
          if (k_d != c_SEG) lenerr_d = 1'b1;
          k_d = 8'd0;  state_d = ST_SOLVE;
        end
      end
      ST_SOLVE: begin
        k_d = k_q + 8'd1;
        case (k_q)
          8'd0: begin
            invs0_d = w_inv;
            dt_d    = gf_mul(s1_q, s1_q) ^ gf_mul(s0_q, s2_q);
          end
          8'd1: begin
            invdt_d = w_inv;
            xs_d    = gf_mul(s1_q, invs0_q);
            sig1n_d = gf_mul(s0_q, s3_q) ^ gf_mul(s1_q, s2_q);
          end
          default: begin
            sig1_d    = w_sig1;
            sig2_d    = gf_mul(gf_mul(s1_q, s3_q) ^ gf_mul(s2_q, s2_q), invdt_q);
            invsig1_d = w_inv;
            if (lenerr_q) mode_d = M_FAIL;
            else if ({s0_q, s1_q, s2_q, s3_q} == 32'd0) mode_d = M_NONE;
            else if (dt_q == 8'h00 && s0_q != 8'h00 && s1_q != 8'h00 &&
                     gf_mul(s1_q, s3_q) == gf_mul(s2_q, s2_q)) mode_d = M_ONE;
            else if (dt_q != 8'h00 && w_sig1 != 8'h00) mode_d = M_TWO;
            else mode_d = M_FAIL;
            roots_d = 2'd0;  loc_d = 8'hFF;  k_d = 8'd0;  state_d = ST_SEARCH;
          end
        endcase
      end
      ST_SEARCH: begin
        roots_d = w_roots_nx;
        loc_d   = loc_step(loc_q);
        k_d     = k_q + 8'd1;
        if (k_q == c_LAST) begin
          mode_d = w_mode_fin;  loc_d = loc_step(8'hFF);  k_d = 8'd1;  state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (k_q < c_NOUT) begin
          k_d = k_q + 8'd1;  loc_d = loc_step(loc_q);
        end else begin
          k_d = 8'd0;  lenerr_d = 1'b0;  state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (w_emitting) begin
      dov_d  = 1'b1;
      dout_d = w_dout;
      if (w_eidx == c_OLAST) begin
        done_d = 1'b1;
        errc_d = (w_emode == M_ONE) ? 2'd1 : (w_emode == M_TWO) ? 2'd2 : 2'd0;
        unc_d  = (w_emode == M_FAIL);
      end
    end
    if (abort) begin
      state_d = ST_IDLE;  k_d = 8'd0;  lenerr_d = 1'b0;  w_we = 1'b0;
      dov_d = 1'b0;  done_d = 1'b0;  errc_d = 2'd0;  unc_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) mem[w_waddr] <= dataI;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;  mode_q <= M_NONE;  k_q <= 8'd0;      lenerr_q <= 1'b0;
      s0_q <= 8'h00;       s1_q <= 8'h00;     s2_q <= 8'h00;    s3_q <= 8'h00;
      invs0_q <= 8'h00;    dt_q <= 8'h00;     invdt_q <= 8'h00; xs_q <= 8'h00;
      sig1n_q <= 8'h00;    sig1_q <= 8'h00;   sig2_q <= 8'h00;  invsig1_q <= 8'h00;
      roots_q <= 2'd0;     loc_q <= 8'hFF;    dout_q <= 8'h00;
      dov_q <= 1'b0;       done_q <= 1'b0;    errc_q <= 2'd0;   unc_q <= 1'b0;
    end else begin
      state_q <= state_d;  mode_q <= mode_d;  k_q <= k_d;       lenerr_q <= lenerr_d;
      s0_q <= s0_d;        s1_q <= s1_d;      s2_q <= s2_d;     s3_q <= s3_d;
      invs0_q <= invs0_d;  dt_q <= dt_d;      invdt_q <= invdt_d; xs_q <= xs_d;
      sig1n_q <= sig1n_d;  sig1_q <= sig1_d;  sig2_q <= sig2_d; invsig1_q <= invsig1_d;
      roots_q <= roots_d;  loc_q <= loc_d;    dout_q <= dout_d;
      dov_q <= dov_d;      done_q <= done_d;  errc_q <= errc_d; unc_q <= unc_d;
    end
  end

  assign busy          = (state_q == ST_SOLVE) || (state_q == ST_SEARCH) || (state_q == ST_EMIT);
  assign dataO         = dout_q;
  assign dataOValid    = dov_q;
  assign segDone       = done_q;
  assign errCount      = errc_q;
  assign uncorrectable = unc_q;

endmodule
`default_nettype wire

// File: tb/tb_corrector.sv
`default_nettype none
// tb_corrector : directed segment table for the RS(t=2) corrector, plus abort sequence.
module tb_corrector;
  localparam int SEG_LEN = 176;
`ifdef RSDEC_STRIP_PARITY_EN
  localparam int N_OUT = SEG_LEN - 4;
`else
  localparam int N_OUT = SEG_LEN;
`endif

  logic       clk = 1'b0, reset = 1'b0, abort = 1'b0;
  logic [7:0] dataI = 8'h00, s0 = 8'h00, s1 = 8'h00, s2 = 8'h00, s3 = 8'h00;
  logic       dataValid = 1'b0, synReady = 1'b0;
  logic       busy, dataOValid, segDone, uncorrectable;
  logic [7:0] dataO;
  logic [1:0] errCount;

  corrector #(.SEG_LEN(SEG_LEN)) dut (
    .clk(clk), .reset(reset), .abort(abort), .dataI(dataI), .dataValid(dataValid),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .synReady(synReady),
    .busy(busy), .dataO(dataO), .dataOValid(dataOValid), .segDone(segDone),
    .errCount(errCount), .uncorrectable(uncorrectable)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, aa, bb;
    r = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) r = r ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
      bb = bb >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] tinv(input logic [7:0] a);
    for (int x = 1; x < 256; x++)
      if (tmul(a, 8'(x)) == 8'h01) return 8'(x);
    return 8'h00;
  endfunction

  function automatic logic [7:0] tpow(input logic [7:0] x, input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < j; i++) r = tmul(r, x);
    return r;
  endfunction

  logic [7:0] xl   [SEG_LEN];   // X(k) = 0xFF * alpha^-k, alpha^-1 = 0x8E
  logic [7:0] errv [SEG_LEN];
  logic [7:0] mmem [SEG_LEN];   // model of the segment buffer contents
  logic [7:0] expo [SEG_LEN];
  logic [7:0] rxd  [256];

  function automatic logic [3:0][7:0] calc_syn();
    logic [3:0][7:0] s;
    s = '0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < SEG_LEN; k++)
        if (errv[k] != 8'h00) s[j] = s[j] ^ tmul(errv[k], tpow(xl[k], j));
    return s;
  endfunction

  // Decoder outcome from the syndromes alone: 0 none, 1 one, 2 two, 3 fail
  function automatic int model_mode(input logic [3:0][7:0] s);
    logic [7:0] dt, a, g1, g2, xs;
    int n;
    n = 0;
    if (s == '0) return 0;
    dt = tmul(s[1], s[1]) ^ tmul(s[0], s[2]);
    if (dt == 8'h00) begin
      if (s[0] == 8'h00 || s[1] == 8'h00 || tmul(s[1], s[3]) != tmul(s[2], s[2])) return 3;
      xs = tmul(s[1], tinv(s[0]));
      for (int k = 0; k < SEG_LEN; k++) if (xl[k] == xs) n++;
      return (n == 1) ? 1 : 3;
    end
    a  = tinv(dt);
    g1 = tmul(tmul(s[0], s[3]) ^ tmul(s[1], s[2]), a);
    g2 = tmul(tmul(s[1], s[3]) ^ tmul(s[2], s[2]), a);
    if (g1 == 8'h00) return 3;
    for (int k = 0; k < SEG_LEN; k++)
      if ((tmul(xl[k], xl[k]) ^ tmul(g1, xl[k]) ^ g2) == 8'h00) n++;
    return (n == 2) ? 2 : 3;
  endfunction

  typedef struct {
    int         nbytes;
    int         syn_gap;   // 0: synReady with the last byte
    int         p0, p1, p2;
    logic [7:0] v0, v1, v2;
    int         exp_err;
    int         exp_unc;
  } vec_t;
  vec_t tbl [6];

  task automatic set_err(input vec_t v);
    for (int k = 0; k < SEG_LEN; k++) errv[k] = 8'h00;
    if (v.p0 >= 0) errv[v.p0] = v.v0;
    if (v.p1 >= 0) errv[v.p1] = v.v1;
    if (v.p2 >= 0) errv[v.p2] = v.v2;
  endtask

  task automatic run_case(input vec_t v, input int cid, input bit do_abort);
    logic [3:0][7:0] sy;
    int T, idx, done, tmp, saw;
    T = 0;
    set_err(v);
    sy = calc_syn();
    for (int k = 0; k < 256; k++) begin
      tmp = k * (2 * cid + 1) + cid;
      rxd[k] = 8'(tmp) ^ ((k < SEG_LEN) ? errv[k] : 8'h00);
    end
    for (int i = 0; i < v.nbytes; i++) begin
      @(negedge clk);
      dataValid = 1'b1;
      dataI = rxd[i];
      if (i < SEG_LEN) mmem[i] = rxd[i];
      if (i == v.nbytes - 1 && v.syn_gap == 0) begin
        synReady = 1'b1; {s3, s2, s1, s0} = sy; T = cyc + 1;
      end
    end
    @(negedge clk);
    dataValid = 1'b0; synReady = 1'b0;
    if (v.syn_gap != 0) begin
      synReady = 1'b1; {s3, s2, s1, s0} = sy; T = cyc + 1;
      @(negedge clk);
      synReady = 1'b0;
    end
    chk($sformatf("case%0d busy_after_syn", cid), busy, 1);
    for (int k = 0; k < SEG_LEN; k++) expo[k] = (v.exp_unc != 0) ? mmem[k] : (mmem[k] ^ errv[k]);

    idx = 0; done = 0;
    // A value "in cycle n" is latched by edge n-1; cyc holds the latest edge number.
    for (int c = 0; c < 2 * SEG_LEN + 20 && done == 0; c++) begin
      @(negedge clk);
      if (dataOValid) begin
        if (idx == 0) chk($sformatf("case%0d first_out_cycle", cid), cyc - T, SEG_LEN + 3);
        if (idx < N_OUT) chk($sformatf("case%0d byte%0d", cid, idx), dataO, expo[idx]);
        idx++;
        if (do_abort && idx == 51) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk($sformatf("case%0d abort_valid_drop", cid), dataOValid, 0);
          chk($sformatf("case%0d abort_busy", cid), busy, 0);
          saw = 0;
          for (int w = 0; w < SEG_LEN; w++) begin
            @(negedge clk);
            if (segDone || dataOValid) saw = 1;
          end
          chk($sformatf("case%0d no_output_after_abort", cid), saw, 0);
          done = 2;
        end
      end
      if (done == 0 && segDone) begin
        chk($sformatf("case%0d segdone_cycle", cid), cyc - T, SEG_LEN + 2 + N_OUT);
        chk($sformatf("case%0d out_count", cid), idx, N_OUT);
        chk($sformatf("case%0d errCount", cid), errCount, v.exp_err);
        chk($sformatf("case%0d uncorrectable", cid), uncorrectable, v.exp_unc);
        done = 1;
      end
    end
    chk($sformatf("case%0d finished", cid), (done != 0) ? 1 : 0, 1);
    if (done == 1) begin
      @(negedge clk);
      chk($sformatf("case%0d busy_after_done", cid), busy, 0);
      chk($sformatf("case%0d valid_after_done", cid), dataOValid, 0);
    end
  endtask

  initial begin
    logic [3:0][7:0] sy;
    int pick;
    xl[0] = 8'hFF;
    for (int k = 1; k < SEG_LEN; k++) xl[k] = tmul(xl[k-1], 8'h8E);
    for (int k = 0; k < SEG_LEN; k++) mmem[k] = 8'h00;

    tbl[0] = '{176, 1, -1,  -1,  -1, 8'h00, 8'h00, 8'h00, 0, 0};
    tbl[1] = '{176, 0, 10,  -1,  -1, 8'h5A, 8'h00, 8'h00, 1, 0};
    tbl[2] = '{176, 1,  3, 170,  -1, 8'h01, 8'hC3, 8'h00, 2, 0};
    tbl[3] = '{176, 1,  5,  60, 120, 8'h11, 8'h22, 8'h00, 0, 1};
    tbl[4] = '{100, 1, -1,  -1,  -1, 8'h00, 8'h00, 8'h00, 0, 1};
    tbl[5] = '{178, 0, -1,  -1,  -1, 8'h00, 8'h00, 8'h00, 0, 1};

    // Pick a third error value whose syndromes cannot be read as a <=2 error pattern
    pick = 1;
    for (int v = 1; v < 256; v++) begin
      tbl[3].v2 = 8'(v);
      set_err(tbl[3]);
      sy = calc_syn();
      if (model_mode(sy) == 3) begin
        pick = v;
        break;
      end
    end
    tbl[3].v2 = 8'(pick);

    repeat (3) @(negedge clk);
    chk("reset dataO", dataO, 0);
    chk("reset dataOValid", dataOValid, 0);
    chk("reset segDone", segDone, 0);
    chk("reset errCount", errCount, 0);
    chk("reset uncorrectable", uncorrectable, 0);
    chk("reset busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_case(tbl[i], i, 1'b0);
    run_case(tbl[0], 6, 1'b1);
    run_case(tbl[2], 7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
